// File: rtl/im_mem_arbiter.sv
// im_mem_arbiter: shares one single-port synchronous image memory between the
// VGA pixel fetch engine and the CPU/tester bus. Every access is sequenced as
// IDLE -> GNT -> RSP, giving one access per three cycles. VGA has priority.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   vga_valid_i/vga_addr_i         VGA read request, held until vga_ready_o
//   vga_rdata_o/vga_ready_o        VGA read data, one-cycle completion pulse
//   cpu_valid_i/cpu_addr_i         CPU request, held until cpu_ready_o
//   cpu_wdata_i/cpu_wstrb_i        CPU write data, byte strobes (0 = read)
//   cpu_rdata_o/cpu_ready_o        CPU read data, one-cycle completion pulse
//   mem_en_o/mem_addr_o            registered memory enable and address
//   mem_we_o/mem_wdata_o           registered byte write enables and data
//   mem_rdata_i                    memory read data, one cycle after mem_en_o
//
// Optional feature: define ARB_STARVE_GUARD_EN to let a CPU that has waited
// MAX_WAIT cycles win over VGA; otherwise VGA priority is strict.
module im_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                vga_valid_i,
    input  logic [ADDR_W-1:0]   vga_addr_i,
    output logic [DATA_W-1:0]   vga_rdata_o,
    output logic                vga_ready_o,
    input  logic                cpu_valid_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_wstrb_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic                mem_en_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT_V = 3'd1;
    localparam logic [2:0] GNT_C = 3'd2;
    localparam logic [2:0] RSP_V = 3'd3;
    localparam logic [2:0] RSP_C = 3'd4;

    logic [2:0]          state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W/8-1:0] mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] cpu_wait_q, cpu_wait_d;
    logic          cpu_busy;
    assign cpu_busy = (state_q == GNT_C) || (state_q == RSP_C);
    // Entering GNT_C only happens from IDLE, so clearing on state_d == GNT_C
    // clears exactly on entry; otherwise count waiting cycles, saturating.
    always_comb begin
        cpu_wait_d = (state_d == GNT_C) ? '0
                   : (cpu_valid_i && !cpu_busy && cpu_wait_q != CW'(MAX_WAIT)) ? cpu_wait_q + 1'b1
                   : cpu_wait_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cpu_wait_q <= '0;
        else         cpu_wait_q <= cpu_wait_d;
    end
    assign cpu_win = cpu_valid_i && (!vga_valid_i || cpu_wait_q >= CW'(MAX_WAIT));
`else
    assign cpu_win = cpu_valid_i && !vga_valid_i;
`endif

    always_comb begin
        state_d = (state_q == IDLE)  ? (cpu_win ? GNT_C : vga_valid_i ? GNT_V : IDLE)
                : (state_q == GNT_V) ? RSP_V
                : (state_q == GNT_C) ? RSP_C
                : IDLE;
    end

    // Memory controls are computed from the next state so they appear,
    // registered, in the same cycle the FSM sits in GNT_x.
    assign mem_en_d    = (state_d == GNT_V) || (state_d == GNT_C);
    assign mem_addr_d  = (state_d == GNT_C) ? cpu_addr_i : (state_d == GNT_V) ? vga_addr_i : '0;
    assign mem_we_d    = (state_d == GNT_C) ? cpu_wstrb_i : '0;
    assign mem_wdata_d = (state_d == GNT_C) ? cpu_wdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign vga_ready_o = state_q == RSP_V;
    assign cpu_ready_o = state_q == RSP_C;
    assign vga_rdata_o = vga_ready_o ? mem_rdata_i : '0;
    assign cpu_rdata_o = cpu_ready_o ? mem_rdata_i : '0;
endmodule
